// File: rtl/mux_n_skid_pkg.sv
// Shared types and limits for the N-input select mux with skid output stage.
package mux_n_skid_pkg;

  // Occupancy of the two-entry output stage.
  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_t;

  // Largest supported number of mux inputs.
  localparam int unsigned MUX_N_MAX = 16;

endpackage : mux_n_skid_pkg

// File: rtl/mux_n_1.sv
// Combinational binary-select N:1 mux; out-of-range selects yield zero and err.
module mux_n_1
  import mux_n_skid_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0][WIDTH-1:0] in,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out,
  output logic                       err
);

  // Decode sel against every legal index; no match means an unused code.
  always_comb begin
    out = '0;
    err = 1'b1;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        out = in[i];
        err = 1'b0;
      end
    end
  end

endmodule : mux_n_1

// File: rtl/mux_n_skid.sv
// N-input select mux feeding a registered two-entry skid stage with
// valid/ready handshakes on both sides and a synchronous flush.
module mux_n_skid
  import mux_n_skid_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N_IN  = 4,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_IN-1:0][WIDTH-1:0] in,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out,
  output logic                       out_err,
  output logic                       out_valid,
  input  logic                       out_ready
);

  if (N_IN < 2 || N_IN > MUX_N_MAX) begin : g_bad_n_in
    $error("mux_n_skid: N_IN out of supported range");
  end

  skid_state_t        state_q;
  logic [WIDTH-1:0]   head_q;
  logic               head_err_q;
  logic [WIDTH-1:0]   skid_q;
  logic               skid_err_q;

  logic [WIDTH-1:0]   mux_data;
  logic               mux_err;
  logic               accept;
  logic               pop;

  mux_n_1 #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_mux (
    .in  (in),
    .sel (sel),
    .out (mux_data),
    .err (mux_err)
  );

  // Handshake flags; readiness depends only on registered occupancy.
  always_comb begin
    in_ready  = (state_q != SKID_FULL);
    out_valid = (state_q != SKID_EMPTY);
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  assign out     = head_q;
  assign out_err = head_err_q;

  // Occupancy FSM with head/skid registers; flush overrides all movement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SKID_EMPTY;
      head_q     <= '0;
      head_err_q <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else if (flush) begin
      state_q <= SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            head_q     <= mux_data;
            head_err_q <= mux_err;
            state_q    <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && pop) begin
            head_q     <= mux_data;
            head_err_q <= mux_err;
          end else if (accept) begin
            skid_q     <= mux_data;
            skid_err_q <= mux_err;
            state_q    <= SKID_FULL;
          end else if (pop) begin
            state_q <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            head_q     <= skid_q;
            head_err_q <= skid_err_q;
            state_q    <= SKID_ONE;
          end
        end
        default: state_q <= SKID_EMPTY;
      endcase
    end
  end

endmodule : mux_n_skid

// File: doc/mux_n_skid.md
Name: mux_n_skid

Overview:
- Parametrised N-input, WIDTH-bit select mux followed by a registered 2-entry skid stage with a valid/ready handshake on both sides, plus synchronous flush.
- Successor to the fixed 2:1 64-bit datapath mux.
- Used at pipeline-stage boundaries (operand/forwarding select, writeback select), where the selected value must be registered and held across downstream stalls without losing throughput.

Parameters:
- WIDTH, 64, data width of each input and of the output.
- N_IN, 4, number of mux inputs; legal range 2..16.
- SEL_W, $clog2(N_IN), select width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  [N_IN-1:0][WIDTH-1:0]  candidate data words.
- sel  input  SEL_W  binary index of the input to capture.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- flush  input  1  synchronous discard of all held beats.
- out  output  WIDTH  head-entry data.
- out_err  output  1  head entry was captured with out-of-range sel.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.

Behaviour:
- One clock and one reset: reset is asynchronous and active-low, on reset_n. All state is reset asynchronously by reset_n low and released synchronously.
- Reset values:
  - State is EMPTY.
  - out = 0, out_err = 0, out_valid = 0.
  - Skid data and error bits are 0.
  - in_ready = 1 once reset_n is high.
- Handshake:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready is decoded from registered state only: in_ready = (state != FULL). There is no combinational path from out_ready or in_valid to in_ready.
- Capture:
  - On accept, the entry stores in[sel] and err = (sel >= N_IN).
  - If sel >= N_IN, the stored data is all-zero and err = 1. This can only happen when N_IN is not a power of 2.
- Latency: a beat accepted in cycle t is presented with out_valid = 1 in cycle t+1, when the stage was empty or when it pops in the same cycle.
- Throughput: 1 beat per cycle while out_ready = 1.
- States and transitions (flush = 0):
  - EMPTY: accept → ONE, head = new.
  - ONE, accept & pop → ONE, head = new.
  - ONE, accept & !pop → FULL, skid = new.
  - ONE, !accept & pop → EMPTY.
  - ONE, !accept & !pop → ONE, hold.
  - FULL: pop → ONE, head = skid; otherwise hold. accept is impossible because in_ready = 0.
- out_valid = (state != EMPTY).
- out and out_err show head-register contents. The head register is not cleared on pop or flush; its value is don't-care whenever out_valid = 0.
- Ordering: beats leave in acceptance order. Nothing is dropped or duplicated except by flush.
- flush = 1:
  - Next state is EMPTY regardless of accept or pop; the beat offered that cycle is dropped.
  - A pop in the flush cycle still counts as a completed downstream transfer.
  - in_ready in the cycle after flush is 1.
- Reset mid-operation: all held beats are discarded immediately, asynchronously, and outputs go to their reset values.
- Held data must be stable while out_valid & !out_ready, even if in[] and sel change.

Decomposition:
- Package mux_n_skid_pkg holds:
  - typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_t;
  - the MUX_N_MAX = 16 constant.
- Sub-module mux_n_1: purely combinational, parametrised WIDTH/N_IN binary-select mux. Ports: in, sel, out, err. It outputs zero and err = 1 for an out-of-range sel. The top level contains only the state machine and the head/skid registers.

Test Plan:
- Reset: hold reset_n = 0 with in_valid = 1 → out_valid = 0, out = 0, out_err = 0. After release, in_ready = 1 and no beat is captured until the first clock edge with reset_n = 1.
- Streaming: N_IN = 4, out_ready = 1, in[i] = 64'h1111_1111_1111_1111 * (i+1), sel cycling 0,1,2,3 → out = 64'h1111…, 64'h2222…, 64'h3333…, 64'h4444… on consecutive cycles, each 1 cycle after accept, with in_valid = 1 and in_ready = 1 every cycle.
- Backpressure:
  - out_ready = 0, two beats sel = 2 then 3 → state FULL, in_ready = 0, out = in[2] held stable while in[] is randomised.
  - Then out_ready = 1 → out = captured in[3] next cycle, state ONE.
  - One more out_ready cycle → EMPTY.
- Out-of-range select: N_IN = 3 instance, sel = 3 accepted → out = 0, out_err = 1. The following beat with sel = 1 gives out_err = 0, out = in[1].
- Flush: state FULL, flush = 1 with in_valid = 1 → next cycle out_valid = 0, in_ready = 1, and the offered beat never appears at out.
- Async reset mid-operation: drop reset_n between clock edges while FULL → out_valid falls immediately without a clock edge; after release the first new beat appears alone and no old beat reappears.
